// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and
// the bit-period helper used to derive default timing parameters.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

    localparam int DATA_BITS = 8;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; the reset value is
// chosen per use so an idle line does not look active coming out of reset.
module sync_2ff #(
    parameter int         WIDTH   = 1,
    parameter logic [0:0] RST_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= {WIDTH{RST_VAL}};
            s2_q <= {WIDTH{RST_VAL}};
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: mid-bit sampling, start glitch rejection, stop-bit
// framing check and overrun detection against the downstream FIFO full flag.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_i,
    input  logic                 full_i,
    input  logic                 clr_err_i,
    output logic                 wr_en_o,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        IDX_LAST = 3'(DATA_BITS - 1);

    logic rx_s;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx_i),
        .q_o (rx_s)
    );

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 wr_q, wr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 busy_q, busy_d;
    logic                 ferr_set;
    logic                 ovr_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        shift_d  = shift_q;
        data_d   = data_q;
        wr_d     = 1'b0;
        ferr_set = 1'b0;
        ovr_set  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // A start bit that is high again at mid-bit was only a glitch
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == IDX_LAST) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                        if (full_i) begin
                            ovr_set = 1'b1;
                        end else begin
                            data_d = shift_q;
                            wr_d   = 1'b1;
                        end
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Set takes priority over a simultaneous clear
        ferr_d = ferr_set | (ferr_q & ~clr_err_i);
        ovr_d  = ovr_set  | (ovr_q  & ~clr_err_i);
        busy_d = (state_d != IDLE);
    end

    assign wr_en_o     = wr_q;
    assign data_o      = data_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = busy_q;

endmodule
